// File: rtl/nx_boot_pkg.sv
// Shared definitions for the boot loader: FSM states, frame target codes and header size.
package nx_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_RUN
    } boot_state_t;

    localparam logic [7:0] TGT_INST = 8'h01;
    localparam logic [7:0] TGT_DATA = 8'h02;
    localparam logic [7:0] TGT_REG  = 8'h03;
    localparam logic [7:0] TGT_GO   = 8'hA5;

    localparam int HDR_BYTES = 6;

    function automatic logic is_load_target(input logic [7:0] code);
        return (code == TGT_INST) || (code == TGT_DATA) || (code == TGT_REG);
    endfunction

endpackage

// File: rtl/nx_boot_word_asm.sv
// Little-endian byte-to-word assembler; word/word_done include the byte accepted this cycle.
module nx_boot_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0] idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= 2'd0;
        end else if (clear) begin
            idx_reg <= 2'd0;
        end else if (byte_valid) begin
            idx_reg <= idx_reg + 2'd1;
        end
    end

    // Each lane captures its byte; the lane being written this cycle bypasses the register.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic       lane_hit;

            assign lane_hit = byte_valid && (idx_reg == 2'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= 8'h00;
                end else if (lane_hit) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[gi*8 +: 8] = lane_hit ? byte_data : lane_reg;
        end
    endgenerate

    assign word_done = byte_valid && (idx_reg == 2'd3);

endmodule

// File: rtl/nx_boot_loader.sv
// Parses host load frames from a byte stream and drives the core's init write ports, then releases the core.
module nx_boot_loader
    import nx_boot_pkg::*;
#(
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        inst_ram_wen,
    output logic [31:0] inst_ram_waddr,
    output logic [31:0] inst_ram_wdata,
    output logic        data_ram_wen_initial,
    output logic [31:0] data_ram_waddr_initial,
    output logic [31:0] data_ram_wdata_initial,
    output logic        regfile_wen_initial,
    output logic [4:0]  regfile_waddr_initial,
    output logic [31:0] regfile_wdata_initial,
    output logic        core_run,
    output logic        busy,
    output logic        err
);

    boot_state_t       state_reg, state_next;
    logic [7:0]        tgt_reg;
    logic [2:0]        hdr_cnt_reg;
    logic [7:0]        cnt_lo_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       addr_reg;
    logic              err_reg;

    logic              inst_wen_reg, data_wen_reg, reg_wen_reg;
    logic [31:0]       inst_waddr_reg, inst_wdata_reg;
    logic [31:0]       data_waddr_reg, data_wdata_reg;
    logic [4:0]        reg_waddr_reg;
    logic [31:0]       reg_wdata_reg;

    logic              accept;
    logic              hdr_last;
    logic [CNT_W-1:0]  cnt_hdr;
    logic              asm_valid, asm_clear, asm_done;
    logic [31:0]       asm_word;

    assign in_ready = !rst && ((state_reg == ST_IDLE) || (state_reg == ST_HDR) ||
                               (state_reg == ST_DATA));
    assign accept   = in_valid && in_ready;
    assign hdr_last = (hdr_cnt_reg == 3'(HDR_BYTES - 1));
    assign cnt_hdr  = CNT_W'({in_data, cnt_lo_reg});

    // The first four header bytes (base address) share the assembler with the data words.
    assign asm_valid = accept && (((state_reg == ST_HDR) && (hdr_cnt_reg < 3'd4)) ||
                                  (state_reg == ST_DATA));
    assign asm_clear = (state_reg == ST_IDLE);

    nx_boot_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_done  (asm_done)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_load_target(in_data)) begin
                        state_next = ST_HDR;
                    end else if (in_data == TGT_GO) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_HDR: begin
                if (accept && hdr_last) begin
                    state_next = (cnt_hdr == '0) ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (asm_done) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_next = (cnt_reg == CNT_W'(1)) ? ST_IDLE : ST_DATA;
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            tgt_reg     <= 8'h00;
            hdr_cnt_reg <= 3'd0;
            cnt_lo_reg  <= 8'h00;
            cnt_reg     <= '0;
            addr_reg    <= 32'h0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    hdr_cnt_reg <= 3'd0;
                    if (accept) begin
                        if (is_load_target(in_data)) begin
                            tgt_reg <= in_data;
                        end else if (in_data != TGT_GO) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        hdr_cnt_reg <= hdr_cnt_reg + 3'd1;
                        if (asm_done) begin
                            addr_reg <= asm_word;
                        end
                        if (hdr_cnt_reg == 3'd4) begin
                            cnt_lo_reg <= in_data;
                        end
                        if (hdr_last) begin
                            cnt_reg <= cnt_hdr;
                        end
                    end
                end
                ST_WRITE: begin
                    // Regfile index lives in addr[4:0], so a plain +1 wraps 31 -> 0 there.
                    addr_reg <= (tgt_reg == TGT_REG) ? addr_reg + 32'd1
                                                     : addr_reg + 32'(ADDR_STEP);
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_wen_reg   <= 1'b0;
            data_wen_reg   <= 1'b0;
            reg_wen_reg    <= 1'b0;
            inst_waddr_reg <= 32'h0;
            inst_wdata_reg <= 32'h0;
            data_waddr_reg <= 32'h0;
            data_wdata_reg <= 32'h0;
            reg_waddr_reg  <= 5'd0;
            reg_wdata_reg  <= 32'h0;
        end else begin
            inst_wen_reg <= 1'b0;
            data_wen_reg <= 1'b0;
            reg_wen_reg  <= 1'b0;
            if ((state_reg == ST_DATA) && asm_done) begin
                case (tgt_reg)
                    TGT_INST: begin
                        inst_wen_reg   <= 1'b1;
                        inst_waddr_reg <= addr_reg;
                        inst_wdata_reg <= asm_word;
                    end
                    TGT_DATA: begin
                        data_wen_reg   <= 1'b1;
                        data_waddr_reg <= addr_reg;
                        data_wdata_reg <= asm_word;
                    end
                    TGT_REG: begin
                        reg_wen_reg    <= 1'b1;
                        reg_waddr_reg  <= addr_reg[4:0];
                        reg_wdata_reg  <= asm_word;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign inst_ram_wen           = inst_wen_reg;
    assign inst_ram_waddr         = inst_waddr_reg;
    assign inst_ram_wdata         = inst_wdata_reg;
    assign data_ram_wen_initial   = data_wen_reg;
    assign data_ram_waddr_initial = data_waddr_reg;
    assign data_ram_wdata_initial = data_wdata_reg;
    assign regfile_wen_initial    = reg_wen_reg;
    assign regfile_waddr_initial  = reg_waddr_reg;
    assign regfile_wdata_initial  = reg_wdata_reg;

    assign core_run = (state_reg == ST_RUN);
    assign busy     = (state_reg == ST_HDR) || (state_reg == ST_DATA) || (state_reg == ST_WRITE);
    assign err      = err_reg;

endmodule

// File: tb/tb_nx_boot_loader.sv
// Directed bench for nx_boot_loader: per-cycle vector table plus reset corner sequences.
module tb_nx_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        inst_ram_wen;
    logic [31:0] inst_ram_waddr, inst_ram_wdata;
    logic        data_ram_wen_initial;
    logic [31:0] data_ram_waddr_initial, data_ram_wdata_initial;
    logic        regfile_wen_initial;
    logic [4:0]  regfile_waddr_initial;
    logic [31:0] regfile_wdata_initial;
    logic        core_run, busy, err;

    always #5 clk = ~clk;

    nx_boot_loader #(.ADDR_STEP(4), .CNT_W(16)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_data                (in_data),
        .in_ready               (in_ready),
        .inst_ram_wen           (inst_ram_wen),
        .inst_ram_waddr         (inst_ram_waddr),
        .inst_ram_wdata         (inst_ram_wdata),
        .data_ram_wen_initial   (data_ram_wen_initial),
        .data_ram_waddr_initial (data_ram_waddr_initial),
        .data_ram_wdata_initial (data_ram_wdata_initial),
        .regfile_wen_initial    (regfile_wen_initial),
        .regfile_waddr_initial  (regfile_waddr_initial),
        .regfile_wdata_initial  (regfile_wdata_initial),
        .core_run               (core_run),
        .busy                   (busy),
        .err                    (err)
    );

    // exp_st = {in_ready, inst_wen, data_wen, reg_wen, busy, core_run, err} after the row's clock edge
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [6:0]  exp_st;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    logic e = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   wen_events = 0;

    always @(negedge clk) begin
        if (inst_ram_wen || data_ram_wen_initial || regfile_wen_initial) wen_events++;
    end

    function automatic logic [6:0] status();
        return {in_ready, inst_ram_wen, data_ram_wen_initial, regfile_wen_initial,
                busy, core_run, err};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic rdy, input logic [2:0] wen,
                       input logic bsy, input logic run, input logic [31:0] a, input logic [31:0] dat);
        vec_t t;
        t.v = v; t.d = d;
        t.exp_st = {rdy, wen, bsy, run, e};
        t.exp_addr = a; t.exp_data = dat;
        vecs.push_back(t);
    endtask

    task automatic hb(input logic [7:0] d);
        add(1'b1, d, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [7:0] d, input logic [2:0] wen, input logic [31:0] a,
                      input logic [31:0] dat);
        add(1'b1, d, 1'b0, wen, 1'b1, 1'b0, a, dat);
    endtask

    task automatic gap_data();
        add(1'b0, 8'h00, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic gap_idle();
        add(1'b0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'h0);
        check({tag, "_status"}, 32'(status()), 32'h0);
        check({tag, "_addrs"}, inst_ram_waddr | data_ram_waddr_initial |
                               32'(regfile_waddr_initial), 32'h0);
        check({tag, "_datas"}, inst_ram_wdata | data_ram_wdata_initial | regfile_wdata_initial,
              32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !done; k++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: byte %h not accepted, required acceptance within 20 cycles", b);
        end
    endtask

    initial begin
        logic [31:0] sel_addr, sel_data;
        int base_events;

        // Instruction load: two words at 0x0 and 0x4
        hb(8'h01); hb(8'h00); hb(8'h00); hb(8'h00); hb(8'h00); hb(8'h02); hb(8'h00);
        hb(8'h13); hb(8'h00); hb(8'h00);
        wr(8'h00, 3'b100, 32'h0000_0000, 32'h0000_0013);
        gap_data();
        hb(8'h93); hb(8'h00); hb(8'h10);
        wr(8'h00, 3'b100, 32'h0000_0004, 32'h0010_0093);
        gap_idle();
        // Regfile wrap 31 -> 0; a byte offered during WRITE must be ignored
        hb(8'h03); hb(8'h1F); hb(8'h00); hb(8'h00); hb(8'h00); hb(8'h02); hb(8'h00);
        hb(8'h11); hb(8'h22); hb(8'h33);
        wr(8'h44, 3'b001, 32'd31, 32'h4433_2211);
        add(1'b1, 8'hEE, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0, 32'h0);
        hb(8'h55); hb(8'h66); hb(8'h77);
        wr(8'h88, 3'b001, 32'd0, 32'h8877_6655);
        gap_idle();
        // Zero count: back to IDLE with no writes
        hb(8'h02); hb(8'h00); hb(8'h10); hb(8'h00); hb(8'h00); hb(8'h00);
        add(1'b1, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        // Data RAM address wraps past 0xFFFF_FFFF
        hb(8'h02); hb(8'hFC); hb(8'hFF); hb(8'hFF); hb(8'hFF); hb(8'h02); hb(8'h00);
        hb(8'h01); hb(8'h02); hb(8'h03);
        wr(8'h04, 3'b010, 32'hFFFF_FFFC, 32'h0403_0201);
        gap_data();
        hb(8'h05); hb(8'h06); hb(8'h07);
        wr(8'h08, 3'b010, 32'h0000_0000, 32'h0807_0605);
        gap_idle();
        // Bad target sets sticky err, next frame still loads
        e = 1'b1;
        add(1'b1, 8'h7E, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        hb(8'h01); hb(8'h00); hb(8'h01); hb(8'h00); hb(8'h00); hb(8'h01); hb(8'h00);
        hb(8'hAA); hb(8'hBB); hb(8'hCC);
        wr(8'hDD, 3'b100, 32'h0000_0100, 32'hDDCC_BBAA);
        gap_idle();
        // GO: core released, further bytes refused
        add(1'b1, 8'hA5, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0, 32'h0);
        add(1'b1, 8'h01, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0, 32'h0);
        add(1'b1, 8'h02, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0, 32'h0);
        add(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0, 32'h0);

        #2 rst = 1'b1;
        #2 check_reset("por");
        @(negedge clk);
        rst = 1'b0;
        #1 check("idle_ready", 32'(status()), 32'b1000000);

        foreach (vecs[i]) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_status", i), 32'(status()), 32'(vecs[i].exp_st));
            if (vecs[i].exp_st[5:3] != 3'b000) begin
                case (vecs[i].exp_st[5:3])
                    3'b100:  begin sel_addr = inst_ram_waddr; sel_data = inst_ram_wdata; end
                    3'b010:  begin sel_addr = data_ram_waddr_initial; sel_data = data_ram_wdata_initial; end
                    default: begin sel_addr = 32'(regfile_waddr_initial); sel_data = regfile_wdata_initial; end
                endcase
                check($sformatf("vec%0d_waddr", i), sel_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_wdata", i), sel_data, vecs[i].exp_data);
            end
            $display("vec %0d: v=%b d=%h status=%b", i, vecs[i].v, vecs[i].d, status());
        end
        in_valid = 1'b0;

        // Reset out of RUN clears everything including err and core_run
        rst = 1'b1;
        #1 check_reset("run_rst");
        $display("reset out of RUN applied");
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a data word: nothing written
        base_events = wen_events;
        send_byte(8'h01); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        #1 check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_no_wen", 32'(wen_events - base_events), 32'd0);
        $display("mid-DATA reset applied");

        send_byte(8'h02); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("post_rst_status", 32'(status()), 32'b0010100);
        check("post_rst_waddr", data_ram_waddr_initial, 32'h0000_0040);
        check("post_rst_wdata", data_ram_wdata_initial, 32'h0403_0201);
        @(negedge clk);
        #1 check("post_rst_idle", 32'(status()), 32'b1000000);
        check("post_rst_one_wen", 32'(wen_events - base_events), 32'd1);
        $display("post-reset frame addr=%h data=%h", data_ram_waddr_initial, data_ram_wdata_initial);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nx_boot_loader.md
Name: nx_boot_loader

Overview:
- Writer for the core's test/initialisation ports: instruction RAM write, data RAM init write, regfile init write.
- Receives a byte stream (valid/ready) from a host link (UART/JTAG bridge) and parses load frames.
- Drives the matching init write strobes, then releases the core via core_run.
- Sits beside nx_riscv_top; its outputs connect 1:1 to the top's init inputs.

Parameters:
- ADDR_STEP, 4, increment applied to inst/data RAM address after each word write.
- CNT_W, 16, width of the frame word-count field (fixed 2 header bytes; values above 16 not supported).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_ready  out  1  byte accepted when in_valid & in_ready
- inst_ram_wen  out  1  instruction RAM write strobe
- inst_ram_waddr  out  32  instruction RAM write address
- inst_ram_wdata  out  32  instruction RAM write data
- data_ram_wen_initial  out  1  data RAM init write strobe
- data_ram_waddr_initial  out  32  data RAM init address
- data_ram_wdata_initial  out  32  data RAM init data
- regfile_wen_initial  out  1  regfile init write strobe
- regfile_waddr_initial  out  5  regfile init index
- regfile_wdata_initial  out  32  regfile init data
- core_run  out  1  1 = core released from hold
- busy  out  1  frame in progress (state not IDLE/RUN)
- err  out  1  sticky: unknown target byte seen

Behaviour:
- Reset (async, rst=1): state IDLE; all wen outputs 0; all addr/data outputs 0; core_run=0; err=0; busy=0; in_ready=0 while rst is high.
- Frame format, little-endian:
  - byte0 target: 0x01 inst, 0x02 data, 0x03 regfile, 0xA5 GO.
  - bytes1-4 base address.
  - bytes5-6 word count N.
  - then N×4 data bytes.
- States: IDLE, HDR, DATA, WRITE, RUN.
- IDLE:
  - in_ready=1.
  - On an accepted byte: 0x01/0x02/0x03 latch target -> HDR with hdr_cnt=0.
  - 0xA5 -> RUN.
  - Any other value -> err<=1, byte discarded, stay IDLE.
- HDR:
  - in_ready=1; accept 6 bytes into addr[31:0] and cnt[15:0].
  - After the 6th byte: cnt==0 -> IDLE (no writes); else -> DATA with byte_cnt=0.
- DATA:
  - in_ready=1; shift bytes into word register, LSB first.
  - The 4th byte -> WRITE.
- WRITE (exactly 1 cycle):
  - in_ready=0.
  - Exactly one wen asserted for this cycle, selected by target; the other two stay 0.
  - waddr/wdata valid in the same cycle.
  - Latency: wen is high the cycle after the 4th data byte handshake.
  - Then addr += ADDR_STEP (inst/data, 32-bit wrap at 0xFFFF_FFFF) or +1 (regfile, 5-bit wrap 31->0); cnt -= 1.
  - cnt reaches 0 -> IDLE, else -> DATA.
- Regfile target:
  - regfile_waddr_initial = addr[4:0]; upper address bits are ignored.
  - Writes to index 0 are issued; the regfile discards them.
- RUN:
  - Terminal until reset; core_run=1, in_ready=0, no writes.
- Outputs are registered: waddr/wdata hold their last value when wen=0.
- busy=1 in HDR, DATA, WRITE.
- A stalled in_valid (low) in HDR/DATA simply waits; there is no timeout.
- err is cleared only by rst.
- Reset mid-frame: partial word discarded, no wen, core_run=0.

Decomposition:
- Shared package nx_boot_pkg holds:
  - state enum;
  - target codes TGT_INST=8'h01, TGT_DATA=8'h02, TGT_REG=8'h03, TGT_GO=8'hA5;
  - HDR_BYTES=6.
- One natural sub-module: nx_boot_word_asm, a byte-to-32-bit LE assembler with byte counter and word_done pulse. It is reused by HDR (address field) and DATA.

Test Plan:
- Inst load: bytes 01, 00 00 00 00, 02 00, 13 00 00 00, 93 00 10 00 -> inst_ram_wen pulses twice:
  - first pulse (addr 0x0, data 0x0000_0013);
  - second pulse (addr 0x4, data 0x0010_0093).
  - No other wen asserted.
- Regfile wrap: 03, 1F 00 00 00, 02 00, then 8 data bytes -> regfile_wen_initial at index 31, then 0.
- Zero count: 02, 00 10 00 00, 00 00 -> no wen; state IDLE; busy low afterwards.
- Bad target: 7E then 01 frame -> err=1 and stays 1; the following frame loads normally.
- GO: A5 -> core_run=1 next cycle; in_ready=0; further bytes are not accepted and cause no writes.
- Reset mid-DATA: rst pulse after 2 data bytes -> no wen; core_run=0; the next full frame writes correctly from its own base address.
